dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter IB_DEPTH, default 16, instruction-buffer entries mirrored by the occupancy counter.
REQ-002 Parameter ROB_SIZE, default 32, ROB entries available as dispatch credits.
REQ-003 Parameter RECOVER_CYCLES, default 2, dispatch-blocked cycles after a squash; legal range 1..15.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 if_wr_cnt  in  2  instructions written into the instruction buffer this cycle; legal values 0..2.
REQ-007 rob_retire_cnt  in  2  ROB entries freed this cycle; legal values 0..2.
REQ-008 rs_free_cnt  in  2  free reservation-station slots this cycle; legal values 0..2.
REQ-009 squashed_sig_rob  in  1  ROB squash, same signal that clears the instruction buffer.
REQ-010 stall_ext  in  1  external dispatch hold.
REQ-011 dp_packet_req  out  2  dispatch request to buffer: 00 none, 01 one, 10 two; 11 never driven.
REQ-012 ib_occupancy  out  5  mirrored buffer occupancy, range 0..IB_DEPTH.
REQ-013 rob_credits  out  6  free ROB entries, range 0..ROB_SIZE.
REQ-014 ctrl_state  out  2  encoded state: 00 IDLE, 01 RUN, 10 RECOVER.
REQ-015 ovf_err  out  1  sticky occupancy-overflow flag.
REQ-016 perf_disp_cnt  out  32  dispatched-instruction counter.
REQ-017 perf_stall_cnt  out  32  stalled-cycle counter.

Function
REQ-018 n SHALL be computed combinationally as min(2, ib_occupancy, rob_credits, rs_free_cnt) in RUN; n SHALL be 0 in IDLE, in RECOVER, when stall_ext=1, or when squashed_sig_rob=1.
REQ-019 dp_packet_req SHALL encode n in the same cycle (zero-cycle latency): 0->00, 1->01, 2->10.
REQ-020 Occupancy next = occ + w - n, where w = if_wr_cnt when occ < IB_DEPTH and w = 0 when occ = IB_DEPTH (matches buffer full-drop).
REQ-021 If occ + w - n > IB_DEPTH, occupancy SHALL clamp to IB_DEPTH and ovf_err SHALL set; ovf_err clears only on reset.
REQ-022 Credits next = min(ROB_SIZE, cred - n + rob_retire_cnt); simultaneous dispatch and retire SHALL be applied in the same cycle.
REQ-023 IDLE->RUN when next occupancy > 0; RUN->IDLE when next occupancy = 0.
REQ-024 squashed_sig_rob=1 in any state SHALL, at the next edge: enter RECOVER, set occupancy to 0, set credits to ROB_SIZE, and load the recovery counter with RECOVER_CYCLES-1.
REQ-025 Squash SHALL override same-cycle if_wr_cnt, rob_retire_cnt, and dispatch.
REQ-026 In RECOVER, if_wr_cnt SHALL accumulate into occupancy per REQ-020 with n=0; the counter decrements each cycle.
REQ-027 When the recovery counter is 0, next state SHALL be RUN if next occupancy > 0, else IDLE.
REQ-028 A squash while in RECOVER SHALL reload the counter and re-clear occupancy and credits.
REQ-029 No other transitions exist; unused encoding 11 SHALL return to IDLE at the next edge.

Reset
REQ-030 reset_n low SHALL asynchronously force: ctrl_state IDLE, ib_occupancy 0, rob_credits ROB_SIZE, recovery counter 0, ovf_err 0, perf counters 0.
REQ-031 During reset, dp_packet_req SHALL be 00.
REQ-032 Reset deassertion mid-operation SHALL restart from the reset state with no residual credits.

Configuration
REQ-033 With DISPATCH_PERF_EN defined:
 - perf_disp_cnt SHALL add n each cycle.
 - perf_stall_cnt SHALL increment in RUN cycles where occ > 0 and n = 0.
 - Both counters wrap modulo 2^32.
REQ-034 Without DISPATCH_PERF_EN, perf_disp_cnt and perf_stall_cnt SHALL be tied to 0 and no counter flops SHALL be inferred.

Verification
REQ-035 Reset then if_wr_cnt=2 for one cycle, rs_free_cnt=2 -> next cycle RUN, occupancy 2, dp_packet_req=10; following cycle occupancy 0, IDLE.
REQ-036 Credits limited: rob_credits=1, occupancy 5, rs_free_cnt=2 -> dp_packet_req=01, credits 0; then dp_packet_req=00 until rob_retire_cnt=2 -> credits 2.
REQ-037 Full: occupancy 16 with if_wr_cnt=2 and n=0 -> occupancy stays 16, ovf_err stays 0; forced overflow via occupancy 15, w=2, n=0 -> occupancy 16, ovf_err=1.
REQ-038 Squash in RUN with occupancy 9, credits 20 -> next edge RECOVER, occupancy 0, credits 32, dp_packet_req=00 for 2 cycles, then RUN if writes arrived, else IDLE.
REQ-039 Squash on cycle 1 of RECOVER -> counter reloads; total blocked span = 3 cycles; reset_n low mid-RECOVER -> immediate IDLE, credits 32.
REQ-040 DISPATCH_PERF_EN defined: 10 cycles of n=2 plus 3 stalled RUN cycles -> perf_disp_cnt=20, perf_stall_cnt=3; macro undefined -> both read 0.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - dispatch width/credit controller with squash recovery
// Optional perf counters enabled by DISPATCH_PERF_EN.
module dispatch_ctrl #(
  parameter int IB_DEPTH       = 16,
  parameter int ROB_SIZE       = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  if_wr_cnt,
  input  logic [1:0]  rob_retire_cnt,
  input  logic [1:0]  rs_free_cnt,
  input  logic        squashed_sig_rob,
  input  logic        stall_ext,
  output logic [1:0]  dp_packet_req,
  output logic [4:0]  ib_occupancy,
  output logic [5:0]  rob_credits,
  output logic [1:0]  ctrl_state,
  output logic        ovf_err,
  output logic [31:0] perf_disp_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_RECOVER = 2'b10,
    S_UNUSED  = 2'b11
  } state_t;

  localparam logic [6:0] IB_MAX   = 7'(IB_DEPTH);
  localparam logic [6:0] ROB_MAX  = 7'(ROB_SIZE);
  localparam logic [3:0] RCV_LOAD = 4'(RECOVER_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] occ_q, occ_d;
  logic [5:0] cred_q, cred_d;
  logic [3:0] rcv_q, rcv_d;
  logic       ovf_q, ovf_d;
  logic [1:0] lim;
  logic [1:0] n;
  logic [1:0] w;
  logic [6:0] occ_sum;
  logic [6:0] cred_sum;

  // Dispatch width: min(2, occupancy, credits, free RS slots), only while running unblocked.
  always_comb begin
    lim = 2'd2;
    if (occ_q < 5'd2)
      lim = occ_q[1:0];
    if (cred_q < {4'b0, lim})
      lim = cred_q[1:0];
    if (rs_free_cnt < lim)
      lim = rs_free_cnt;
    n = 2'd0;
    if (state_q == S_RUN && !stall_ext && !squashed_sig_rob)
      n = lim;
  end

  // Writes into a full buffer are dropped by the buffer itself, so they are not counted.
  assign w        = ({2'b0, occ_q} < IB_MAX) ? if_wr_cnt : 2'd0;
  assign occ_sum  = {2'b0, occ_q} + {5'b0, w} - {5'b0, n};
  assign cred_sum = {1'b0, cred_q} - {5'b0, n} + {5'b0, rob_retire_cnt};

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    cred_d  = cred_q;
    rcv_d   = rcv_q;
    ovf_d   = ovf_q;
    if (squashed_sig_rob) begin
      state_d = S_RECOVER;
      occ_d   = '0;
      cred_d  = ROB_MAX[5:0];
      rcv_d   = RCV_LOAD;
    end else begin
      if (occ_sum > IB_MAX) begin
        occ_d = IB_MAX[4:0];
        ovf_d = 1'b1;
      end else begin
        occ_d = occ_sum[4:0];
      end
      cred_d = (cred_sum > ROB_MAX) ? ROB_MAX[5:0] : cred_sum[5:0];
      case (state_q)
        S_IDLE: begin
          if (occ_d != '0)
            state_d = S_RUN;
        end
        S_RUN: begin
          if (occ_d == '0)
            state_d = S_IDLE;
        end
        S_RECOVER: begin
          if (rcv_q == '0)
            state_d = (occ_d != '0) ? S_RUN : S_IDLE;
          else
            rcv_d = rcv_q - 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      occ_q   <= '0;
      cred_q  <= ROB_MAX[5:0];
      rcv_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cred_q  <= cred_d;
      rcv_q   <= rcv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dp_packet_req = n;
  assign ib_occupancy  = occ_q;
  assign rob_credits   = cred_q;
  assign ctrl_state    = state_q;
  assign ovf_err       = ovf_q;

`ifdef DISPATCH_PERF_EN
  logic [31:0] disp_q;
  logic [31:0] stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_q  <= '0;
      stall_q <= '0;
    end else begin
      disp_q <= disp_q + {30'b0, n};
      if (state_q == S_RUN && occ_q != '0 && n == 2'd0)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_disp_cnt  = disp_q;
  assign perf_stall_cnt = stall_q;
`else
  assign perf_disp_cnt  = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - scoreboard bench for dispatch_ctrl with a behavioural reference model
module tb_dispatch_ctrl;

  localparam int IB  = 16;
  localparam int ROB = 32;
  localparam int RC  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  if_wr_cnt = '0;
  logic [1:0]  rob_retire_cnt = '0;
  logic [1:0]  rs_free_cnt = '0;
  logic        squashed_sig_rob = 1'b0;
  logic        stall_ext = 1'b0;
  logic [1:0]  dp_packet_req;
  logic [4:0]  ib_occupancy;
  logic [5:0]  rob_credits;
  logic [1:0]  ctrl_state;
  logic        ovf_err;
  logic [31:0] perf_disp_cnt;
  logic [31:0] perf_stall_cnt;

  dispatch_ctrl #(.IB_DEPTH(IB), .ROB_SIZE(ROB), .RECOVER_CYCLES(RC)) dut (
    .clock(clock), .reset_n(reset_n), .if_wr_cnt(if_wr_cnt),
    .rob_retire_cnt(rob_retire_cnt), .rs_free_cnt(rs_free_cnt),
    .squashed_sig_rob(squashed_sig_rob), .stall_ext(stall_ext),
    .dp_packet_req(dp_packet_req), .ib_occupancy(ib_occupancy),
    .rob_credits(rob_credits), .ctrl_state(ctrl_state), .ovf_err(ovf_err),
    .perf_disp_cnt(perf_disp_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          dp;
    int          st;
    int          occ;
    int          cred;
    int          ovf;
    logic [31:0] pd;
    logic [31:0] ps;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 recover; m_left = blocked cycles still to serve.
  int          m_mode, m_occ, m_cred, m_left;
  int          m_ovf;
  logic [31:0] m_pd, m_ps;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_occ = 0; m_cred = ROB; m_left = 0; m_ovf = 0;
    m_pd = '0; m_ps = '0;
  endtask

  task automatic do_cycle(input bit rstn, input int wr, input int ret, input int rs,
                          input bit sq, input bit st);
    exp_t e;
    int n, w, s;
    @(negedge clock);
    reset_n = rstn;
    if_wr_cnt = 2'(wr);
    rob_retire_cnt = 2'(ret);
    rs_free_cnt = 2'(rs);
    squashed_sig_rob = sq;
    stall_ext = st;
    if (!rstn) model_reset();
    n = 0;
    if (rstn && m_mode == 1 && !st && !sq)
      n = imin(imin(2, m_occ), imin(m_cred, rs));
    e.dp = n; e.st = m_mode; e.occ = m_occ; e.cred = m_cred; e.ovf = m_ovf;
`ifdef DISPATCH_PERF_EN
    e.pd = m_pd; e.ps = m_ps;
`else
    e.pd = '0; e.ps = '0;
`endif
    sbq.push_back(e);
    if (rstn) begin
      m_pd = m_pd + 32'(n);
      if (m_mode == 1 && m_occ > 0 && n == 0) m_ps = m_ps + 32'd1;
      if (sq) begin
        m_mode = 2; m_occ = 0; m_cred = ROB; m_left = RC;
      end else begin
        w = (m_occ < IB) ? wr : 0;
        s = m_occ + w - n;
        if (s > IB) begin
          m_occ = IB; m_ovf = 1;
        end else begin
          m_occ = s;
        end
        m_cred = imin(ROB, m_cred - n + ret);
        if (m_mode == 0) begin
          if (m_occ > 0) m_mode = 1;
        end else if (m_mode == 1) begin
          if (m_occ == 0) m_mode = 0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = (m_occ > 0) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("dp_packet_req", dp_packet_req, e.dp);
        chk("ctrl_state", ctrl_state, e.st);
        chk("ib_occupancy", ib_occupancy, e.occ);
        chk("rob_credits", rob_credits, e.cred);
        chk("ovf_err", ovf_err, e.ovf);
        chk("perf_disp_cnt", perf_disp_cnt, e.pd);
        chk("perf_stall_cnt", perf_stall_cnt, e.ps);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int guard;
    int bias;
    model_reset();
    repeat (3) do_cycle(0, 0, 0, 0, 0, 0);

    // write two, dispatch two, back to idle
    do_cycle(1, 2, 0, 2, 0, 0);
    repeat (3) do_cycle(1, 0, 0, 2, 0, 0);

    // full buffer drop, then forced overflow from 15
    do_cycle(0, 0, 0, 0, 0, 0);
    repeat (9) do_cycle(1, 2, 0, 0, 0, 1);
    do_cycle(1, 0, 0, 1, 0, 0);
    do_cycle(1, 2, 0, 0, 0, 1);
    repeat (2) do_cycle(1, 0, 0, 0, 0, 1);

    // credit-limited dispatch
    do_cycle(0, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_cred > 1 && guard < 100) begin
      do_cycle(1, (m_occ < 7) ? 2 : 0, 0, (m_cred >= 3) ? 2 : 1, 0, 0);
      guard++;
    end
    guard = 0;
    while (m_occ < 5 && guard < 10) begin
      do_cycle(1, 1, 0, 0, 0, 1);
      guard++;
    end
    do_cycle(1, 0, 0, 2, 0, 0);
    repeat (3) do_cycle(1, 0, 0, 2, 0, 0);
    do_cycle(1, 0, 2, 2, 0, 0);
    repeat (2) do_cycle(1, 0, 0, 2, 0, 1);

    // squash in RUN, recovery without and with writes
    do_cycle(0, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_cred > 20 && guard < 40) begin
      do_cycle(1, 2, 0, (m_cred - 20 >= 2) ? 2 : 1, 0, 0);
      guard++;
    end
    guard = 0;
    while (m_occ < 9 && guard < 10) begin
      do_cycle(1, (m_occ == 8) ? 1 : 2, 0, 0, 0, 1);
      guard++;
    end
    do_cycle(1, 2, 2, 2, 1, 0);
    repeat (3) do_cycle(1, 0, 0, 2, 0, 0);
    do_cycle(1, 0, 0, 2, 1, 0);
    do_cycle(1, 1, 0, 2, 0, 0);
    repeat (3) do_cycle(1, 0, 0, 2, 0, 0);

    // squash during recovery, then reset during recovery
    do_cycle(1, 0, 0, 2, 1, 0);
    do_cycle(1, 0, 0, 2, 1, 0);
    repeat (4) do_cycle(1, 0, 0, 2, 0, 0);
    do_cycle(1, 2, 0, 2, 1, 0);
    do_cycle(0, 2, 0, 2, 0, 0);
    do_cycle(1, 0, 0, 2, 0, 0);

    // perf: ten double dispatches then three stalled RUN cycles
    do_cycle(0, 0, 0, 0, 0, 0);
    repeat (2) do_cycle(1, 2, 0, 0, 0, 1);
    repeat (10) do_cycle(1, 2, 2, 2, 0, 0);
    repeat (3) do_cycle(1, 0, 1, 2, 0, 1);

    // randomized traffic with occasional squash, stall and reset
    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = int'($urandom_range(0, 2));
      do_cycle(($urandom_range(0, 599) != 0),
               (bias == 2) ? 2 : int'($urandom_range(bias, 2)),
               int'($urandom_range(0, 2)),
               (bias == 2) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2)),
               ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 7) == 0));
    end

    repeat (2) do_cycle(1, 0, 0, 0, 0, 0);
    @(negedge clock);
    #5;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
